// File: rtl/sub8_serial_if.sv
// sub8_serial_if: start/busy/done handshake and operand/result bus for sub8_serial.
interface sub8_serial_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             bin;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             ovfl;
  logic             busy;
  logic             done;
  modport master (output start, A, B, bin, input D, Bout, ovfl, busy, done);
  modport slave  (input start, A, B, bin, output D, Bout, ovfl, busy, done);
endinterface

// File: rtl/sub8_serial.sv
// sub8_serial: bit-serial A - B - bin using one full-subtractor cell, LSB first.
module sub8_serial #(parameter int WIDTH = 8) (
  input logic         clk,
  input logic         reset,
  sub8_serial_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_r, r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_br, r_asign, r_bsign, r_bout, r_ovfl, r_done;
  logic             w_d, w_brn, w_last, w_load;
  logic [WIDTH-1:0] w_res;
  assign w_d    = r_a[0] ^ r_b[0] ^ r_br;
  assign w_brn  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_res  = {w_d, r_r[WIDTH-1:1]};
  assign w_load = (r_state == IDLE) && bus.start;
  assign w_last = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));
  always_comb begin
    w_next = r_state;
    w_next = w_load ? SHIFT : w_last ? IDLE : r_state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_asign <= 1'b0;
      r_bsign <= 1'b0;
      r_bout  <= 1'b0;
      r_ovfl  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_a     <= bus.A;
        r_b     <= bus.B;
        r_br    <= bus.bin;
        r_cnt   <= '0;
        r_asign <= bus.A[WIDTH-1];
        r_bsign <= bus.B[WIDTH-1];
      end else if (r_state == SHIFT) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_r   <= w_res;
        r_br  <= w_brn;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_d    <= w_res;
          r_bout <= w_brn;
          r_ovfl <= (r_asign != r_bsign) && (w_d != r_asign);
        end
      end
    end
  assign bus.D    = r_d;
  assign bus.Bout = r_bout;
  assign bus.ovfl = r_ovfl;
  assign bus.busy = (r_state == SHIFT);
  assign bus.done = r_done;
endmodule

// File: tb/tb_sub8_serial.sv
// tb_sub8_serial: directed checks of arithmetic, latency, handshake and reset abort.
module tb_sub8_serial;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;
  int   cyc;
  int   dones;
  sub8_serial_if #(.WIDTH(8)) bus();
  sub8_serial #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(output int c);
    c = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      c++;
      if (bus.done) break;
    end
  endtask
  task automatic run(input string t, input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] ed, input logic eb, input logic eo);
    int k;
    bus.start = 1'b1; bus.A = a; bus.B = b; bus.bin = c;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.A = ~a; bus.B = ~b; bus.bin = ~c;
    chk({t, ".busy"}, bus.busy, 1);
    wait_done(k);
    chk({t, ".lat"}, k, 8);
    chk({t, ".D"}, bus.D, ed);
    chk({t, ".Bout"}, bus.Bout, eb);
    chk({t, ".ovfl"}, bus.ovfl, eo);
    @(posedge clk); #1;
    chk({t, ".done_clr"}, bus.done, 0);
    chk({t, ".idle"}, bus.busy, 0);
  endtask
  initial begin
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.bin = 1'b0;
    #12;
    chk("rst.D", bus.D, 0);
    chk("rst.flags", {bus.Bout, bus.ovfl, bus.busy, bus.done}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    run("5m3",  8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run("3m5",  8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run("80m1", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run("7FmFF",8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run("0m0b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    // stray start mid-operation must be ignored
    bus.start = 1'b1; bus.A = 8'h10; bus.B = 8'h01; bus.bin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
      if (i == 3) begin bus.start = 1'b1; bus.A = 8'hAA; bus.B = 8'h00; end
      if (i == 4) bus.start = 1'b0;
    end
    chk("mid.dones", dones, 1);
    chk("mid.D", bus.D, 8'h0F);
    chk("mid.flags", {bus.Bout, bus.ovfl}, 0);
    bus.start = 1'b1; bus.A = 8'h20; bus.B = 8'h01; bus.bin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(cyc);
    chk("b2b.first", bus.D, 8'h1F);
    bus.start = 1'b1; bus.A = 8'h01; bus.B = 8'h01;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b.accept", bus.busy, 1);
    wait_done(cyc);
    chk("b2b.lat", cyc + 1, 9);
    chk("b2b.D", bus.D, 8'h00);
    chk("b2b.Bout", bus.Bout, 0);
    @(posedge clk); #1;
    run("7FmFF2", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    bus.start = 1'b1; bus.A = 8'h55; bus.B = 8'h11;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort.D", bus.D, 0);
    chk("abort.flags", {bus.Bout, bus.ovfl, bus.busy, bus.done}, 0);
    @(negedge clk) reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    chk("abort.nodone", dones, 0);
    chk("abort.idle", bus.busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
